// File: rtl/cmp_seq_pkg.sv
// Shared types and constants for the sequential nibble-compare controller.
package cmp_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/nib_eq4.sv
// Combinational 4-bit equality unit; the single shared compare resource.
module nib_eq4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       eq_o
);

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Two-requester equality compare engine: round-robin accept, then an
// LSB-first nibble walk through one shared nib_eq4 with early exit on mismatch.
module cmp_seq_ctrl
  import cmp_seq_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int IDX_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic [4*NIBBLES-1:0]   req0_a,
  input  logic [4*NIBBLES-1:0]   req0_b,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [4*NIBBLES-1:0]   req1_a,
  input  logic [4*NIBBLES-1:0]   req1_b,
  output logic                   req1_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic                   rsp_eq,
  output logic [IDX_W-1:0]       rsp_idx,
  output logic                   busy
);

  localparam int                W        = 4 * NIBBLES;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               last_q, last_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               id_q, id_d;
  logic               eq_q, eq_d;
  logic [IDX_W-1:0]   rsp_idx_q, rsp_idx_d;

  logic               grant_id;
  logic               nib_match;
  logic [3:0]         nib_a;
  logic [3:0]         nib_b;

  assign nib_a = a_q[4*idx_q +: 4];
  assign nib_b = b_q[4*idx_q +: 4];

  nib_eq4 u_nib_eq4 (
    .a_i  (nib_a),
    .b_i  (nib_b),
    .eq_o (nib_match)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    eq_d       = eq_q;
    rsp_idx_d  = rsp_idx_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    // With both valid, the requester that did not win last time goes next.
    if (req0_valid && req1_valid) grant_id = ~last_q;
    else if (req1_valid)          grant_id = REQ1;
    else                          grant_id = REQ0;

    case (state_q)
      S_IDLE: begin
        if ((req0_valid || req1_valid) && !rst) begin
          req0_ready = (grant_id == REQ0);
          req1_ready = (grant_id == REQ1);
          a_d        = (grant_id == REQ1) ? req1_a : req0_a;
          b_d        = (grant_id == REQ1) ? req1_b : req0_b;
          id_d       = grant_id;
          last_d     = grant_id;
          idx_d      = '0;
          state_d    = S_CMP;
        end
      end
      S_CMP: begin
        if (!nib_match) begin
          eq_d      = 1'b0;
          rsp_idx_d = idx_q;
          state_d   = S_RESP;
        end else if (idx_q == LAST_IDX) begin
          eq_d      = 1'b1;
          rsp_idx_d = LAST_IDX;
          state_d   = S_RESP;
        end else begin
          idx_d     = idx_q + IDX_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      last_q    <= REQ1;
      // NOTE: operand latches are reset too, so an aborted compare leaves no
      // stale data behind.
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      eq_q      <= 1'b0;
      rsp_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      a_q       <= a_d;
      b_q       <= b_d;
      id_q      <= id_d;
      eq_q      <= eq_d;
      rsp_idx_q <= rsp_idx_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_id    = id_q;
  assign rsp_eq    = eq_q;
  assign rsp_idx   = rsp_idx_q;

endmodule

// File: doc/cmp_seq_ctrl.md
Name: cmp_seq_ctrl

Overview:
- Multi-cycle equality-compare controller that shares one 4-bit nibble equality unit between two requesters.
- Each request carries two (4*NIBBLES)-bit operands. The block arbitrates round-robin, latches the operands, and walks the nibbles LSB-first through the shared unit, exiting early on the first mismatch.
- It returns an equal flag and the index of the last nibble compared.
- It sits beside the CPU datapath as the compare engine for branch and tag checks wider than 4 bits.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; operand width = 4*NIBBLES; minimum 2.
- IDX_W, 2, nibble index width; must equal ceil(log2(NIBBLES)).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a compare pending.
- req0_a  input  4*NIBBLES  requester 0 operand A.
- req0_b  input  4*NIBBLES  requester 0 operand B.
- req0_ready  output  1  requester 0 accepted this cycle (combinational).
- req1_valid  input  1  requester 1 has a compare pending.
- req1_a  input  4*NIBBLES  requester 1 operand A.
- req1_b  input  4*NIBBLES  requester 1 operand B.
- req1_ready  output  1  requester 1 accepted this cycle (combinational).
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_id  output  1  requester that owns the result.
- rsp_eq  output  1  1 = operands fully equal.
- rsp_idx  output  IDX_W  first mismatching nibble; NIBBLES-1 when equal.
- busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, CMP, RESP.
- Reset (asynchronous, any time, including mid-CMP or RESP):
  - state=IDLE, idx=0, last_grant=1 (so req0 wins first).
  - All outputs 0.
  - Latched operands are cleared to 0. An in-flight compare is dropped with no response.
- IDLE, grant logic:
  - req0_ready and req1_ready are 0 unless state=IDLE.
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - Exactly one ready is high per cycle, and never without its valid.
- IDLE, on handshake:
  - Latch a, b and the granted id; set last_grant=id, idx=0.
  - Next state = CMP.
- CMP, one nibble per cycle via sub-module (a_lat[4*idx+:4] vs b_lat[4*idx+:4]):
  - Mismatch: rsp_eq=0, rsp_idx=idx, go to RESP.
  - Match and idx==NIBBLES-1: rsp_eq=1, rsp_idx=NIBBLES-1, go to RESP.
  - Otherwise: idx+1, stay in CMP. idx never wraps within a request.
- Latency (handshake in cycle T):
  - Mismatch at nibble k: rsp_valid first high in cycle T+2+k.
  - All equal: rsp_valid first high in cycle T+NIBBLES+1.
- RESP:
  - rsp_valid=1. rsp_id, rsp_eq and rsp_idx are registered and stable until handshake.
  - rsp_valid && rsp_ready: go to IDLE next cycle. No new acceptance occurs in the handshake cycle.
  - rsp_ready is ignored outside RESP.
- Operand inputs change after accept: ignored (operands are latched).
- A requester dropping valid without a handshake has no effect.
- Back-to-back requests: the minimum accept-to-accept interval is 3 cycles (mismatch at nibble 0, rsp_ready held high).

Decomposition:
- Package cmp_seq_pkg holds:
  - State encoding constants S_IDLE=2'd0, S_CMP=2'd1, S_RESP=2'd2.
  - Requester id constants REQ0=1'b0, REQ1=1'b1.
- One sub-module, nib_eq4: combinational 4-bit equality of two nibbles, output 1 when equal. Instantiated exactly once, as the shared resource.

Test Plan:
- Equal operands: reset, then req0 a=b=16'hBEEF with rsp_ready=1.
  - Required: req0_ready in T; rsp_valid in T+5; rsp_eq=1, rsp_idx=3, rsp_id=0; busy low in T+6.
- Early mismatch: req1 a=16'h1234, b=16'h1235.
  - Required: rsp_valid in T+2; rsp_eq=0, rsp_idx=0, rsp_id=1.
- Late mismatch: a=16'hA234, b=16'h5234.
  - Required: rsp_valid in T+5; rsp_eq=0, rsp_idx=3.
- Round-robin: both valid held continuously, rsp_ready=1.
  - Required: grants alternate 0,1,0,1 starting with req0 after reset.
  - Required: no ready asserted while busy.
- Backpressure plus operand change: rsp_ready=0 for 4 cycles after rsp_valid; the requester changes req0_a after accept.
  - Required: rsp_valid and the result fields stay stable; the result reflects the latched operands; completion occurs on the rsp_ready=1 cycle.
- Reset mid-CMP: assert rst at T+2 of a 4-nibble compare.
  - Required: all outputs 0 immediately; no rsp_valid afterwards.
  - Required: the next request after reset release is granted to req0 and completes normally.
